// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one external memory port between Icache refills and Dcache accesses.
// One transaction in flight; Dcache wins ties unless Icache has waited STARVE_LIMIT grants.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Icache_Req,
    input  logic [ADDR_W-1:0]     Icache_Addr,
    output logic                  Icache_Gnt,
    output logic                  Icache_Rvalid,
    output logic [DATA_W-1:0]     Icache_Rdata,
    input  logic                  Dcache_Req,
    input  logic                  Dcache_We,
    input  logic [ADDR_W-1:0]     Dcache_Addr,
    input  logic [DATA_W-1:0]     Dcache_Wdata,
    input  logic [DATA_W/8-1:0]   Dcache_Wstrb,
    output logic                  Dcache_Gnt,
    output logic                  Dcache_Rvalid,
    output logic [DATA_W-1:0]     Dcache_Rdata,
    input  logic                  Csr_Memflush,
    output logic                  Mem_Req,
    output logic                  Mem_We,
    output logic [ADDR_W-1:0]     Mem_Addr,
    output logic [DATA_W-1:0]     Mem_Wdata,
    output logic [DATA_W/8-1:0]   Mem_Wstrb,
    input  logic                  Mem_Ready,
    input  logic                  Mem_Rvalid,
    input  logic [DATA_W-1:0]     Mem_Rdata,
    output logic                  Arb_Busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_I = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic                owner_q,   owner_d;
    logic                drop_q,    drop_d;
    logic [CNT_W-1:0]    starve_q,  starve_d;
    logic                busy_q,    busy_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q,  mem_we_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;

    logic                grant_d_s;
    logic                grant_i_s;

    // Tie-break: Dcache wins unless Icache has been passed over STARVE_LIMIT times in a row
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (Dcache_Req && !(Icache_Req && (starve_q == LIMIT_C))) begin
            grant_d_s = 1'b1;
        end else if (Icache_Req) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    // Next-state logic; the memory-side registers only hold a request while in REQ
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        drop_d    = drop_q;
        starve_d  = starve_q;
        busy_d    = busy_q;
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (grant_d_s) begin
                    state_d   = ST_REQ;
                    owner_d   = OWN_D;
                    busy_d    = 1'b1;
                    mem_req_d = 1'b1;
                    mem_we_d  = Dcache_We;
                    addr_d    = Dcache_Addr;
                    wdata_d   = Dcache_Wdata;
                    wstrb_d   = Dcache_Wstrb;
                    if (!Icache_Req) begin
                        starve_d = {CNT_W{1'b0}};
                    end else if (starve_q != LIMIT_C) begin
                        starve_d = starve_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        starve_d = starve_q;
                    end
                end else if (grant_i_s) begin
                    state_d   = ST_REQ;
                    owner_d   = OWN_I;
                    busy_d    = 1'b1;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    addr_d    = Icache_Addr;
                    wdata_d   = {DATA_W{1'b0}};
                    wstrb_d   = {STRB_W{1'b0}};
                    starve_d  = {CNT_W{1'b0}};
                end else begin
                    starve_d  = {CNT_W{1'b0}};
                end
            end
            ST_REQ: begin
                if (Csr_Memflush && (owner_q == OWN_I)) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
                if (Mem_Ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    addr_d    = {ADDR_W{1'b0}};
                    wdata_d   = {DATA_W{1'b0}};
                    wstrb_d   = {STRB_W{1'b0}};
                end else begin
                    state_d   = ST_REQ;
                end
            end
            ST_RESP: begin
                if (Mem_Rvalid) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    drop_d  = 1'b0;
                end else if (Csr_Memflush && (owner_q == OWN_I)) begin
                    drop_d  = 1'b1;
                end else begin
                    drop_d  = drop_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                drop_d    = 1'b0;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                addr_d    = {ADDR_W{1'b0}};
                wdata_d   = {DATA_W{1'b0}};
                wstrb_d   = {STRB_W{1'b0}};
            end
        endcase
    end

    // Arbiter FSM and its registered memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_D;
            drop_q    <= 1'b0;
            starve_q  <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            drop_q    <= drop_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // Grant and response pulses track the memory handshake in the same cycle
    always_comb begin
        Icache_Gnt    = 1'b0;
        Dcache_Gnt    = 1'b0;
        Icache_Rvalid = 1'b0;
        Dcache_Rvalid = 1'b0;
        if ((state_q == ST_REQ) && Mem_Ready) begin
            Icache_Gnt = (owner_q == OWN_I);
            Dcache_Gnt = (owner_q == OWN_D);
        end else begin
            Icache_Gnt = 1'b0;
            Dcache_Gnt = 1'b0;
        end
        if ((state_q == ST_RESP) && Mem_Rvalid) begin
            Icache_Rvalid = (owner_q == OWN_I) && !drop_q && !Csr_Memflush;
            Dcache_Rvalid = (owner_q == OWN_D);
        end else begin
            Icache_Rvalid = 1'b0;
            Dcache_Rvalid = 1'b0;
        end
    end

    assign Icache_Rdata = Mem_Rdata;
    assign Dcache_Rdata = Mem_Rdata;
    assign Mem_Req      = mem_req_q;
    assign Mem_We       = mem_we_q;
    assign Mem_Addr     = addr_q;
    assign Mem_Wdata    = wdata_q;
    assign Mem_Wstrb    = wstrb_q;
    assign Arb_Busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, write hold, starvation order, flush, reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Icache_Req;
    logic [31:0] Icache_Addr;
    logic        Icache_Gnt, Icache_Rvalid;
    logic [31:0] Icache_Rdata;
    logic        Dcache_Req, Dcache_We;
    logic [31:0] Dcache_Addr, Dcache_Wdata;
    logic [3:0]  Dcache_Wstrb;
    logic        Dcache_Gnt, Dcache_Rvalid;
    logic [31:0] Dcache_Rdata;
    logic        Csr_Memflush;
    logic        Mem_Req, Mem_We;
    logic [31:0] Mem_Addr, Mem_Wdata;
    logic [3:0]  Mem_Wstrb;
    logic        Mem_Ready, Mem_Rvalid;
    logic [31:0] Mem_Rdata;
    logic        Arb_Busy;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Icache_Req(Icache_Req), .Icache_Addr(Icache_Addr), .Icache_Gnt(Icache_Gnt),
        .Icache_Rvalid(Icache_Rvalid), .Icache_Rdata(Icache_Rdata),
        .Dcache_Req(Dcache_Req), .Dcache_We(Dcache_We), .Dcache_Addr(Dcache_Addr),
        .Dcache_Wdata(Dcache_Wdata), .Dcache_Wstrb(Dcache_Wstrb), .Dcache_Gnt(Dcache_Gnt),
        .Dcache_Rvalid(Dcache_Rvalid), .Dcache_Rdata(Dcache_Rdata),
        .Csr_Memflush(Csr_Memflush),
        .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
        .Mem_Wstrb(Mem_Wstrb), .Mem_Ready(Mem_Ready), .Mem_Rvalid(Mem_Rvalid),
        .Mem_Rdata(Mem_Rdata), .Arb_Busy(Arb_Busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic all_outputs_zero(input string tag);
        check_val({tag, "_mem_req"}, Mem_Req, 1'b0);
        check_val({tag, "_mem_we"}, Mem_We, 1'b0);
        check_val({tag, "_mem_addr"}, Mem_Addr, 32'h0);
        check_val({tag, "_mem_wdata"}, Mem_Wdata, 32'h0);
        check_val({tag, "_mem_wstrb"}, Mem_Wstrb, 4'h0);
        check_val({tag, "_busy"}, Arb_Busy, 1'b0);
        check_val({tag, "_gnts"}, {Icache_Gnt, Dcache_Gnt}, 2'b00);
        check_val({tag, "_rvalids"}, {Icache_Rvalid, Dcache_Rvalid}, 2'b00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_is_i;
        int ngrant;
        int gnt_count;

        rst_n = 1'b0;
        Icache_Req = 1'b0; Icache_Addr = 32'h0;
        Dcache_Req = 1'b0; Dcache_We = 1'b0; Dcache_Addr = 32'h0;
        Dcache_Wdata = 32'h0; Dcache_Wstrb = 4'h0;
        Csr_Memflush = 1'b0;
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b0; Mem_Rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        all_outputs_zero("reset");
        tick();
        rst_n = 1'b1;

        // Single Icache read, memory ready immediately
        Icache_Req = 1'b1; Icache_Addr = 32'h0000_1000;
        @(negedge clk);
        check_val("i1_c0_mem_req", Mem_Req, 1'b0);
        tick();
        Mem_Ready = 1'b1;
        @(negedge clk);
        check_val("i1_c1_mem_req", Mem_Req, 1'b1);
        check_val("i1_c1_addr", Mem_Addr, 32'h0000_1000);
        check_val("i1_c1_we", Mem_We, 1'b0);
        check_val("i1_c1_gnts", {Icache_Gnt, Dcache_Gnt}, 2'b10);
        check_val("i1_c1_busy", Arb_Busy, 1'b1);
        tick();
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("i1_c2_rvalids", {Icache_Rvalid, Dcache_Rvalid}, 2'b10);
        check_val("i1_c2_rdata", Icache_Rdata, 32'hDEAD_BEEF);
        check_val("i1_c2_gnt", Icache_Gnt, 1'b0);
        check_val("i1_c2_mem_req", Mem_Req, 1'b0);
        tick();
        Icache_Req = 1'b0; Mem_Rvalid = 1'b0;
        @(negedge clk);
        check_val("i1_c3_busy", Arb_Busy, 1'b0);

        // Dcache write, Mem_Ready delayed three cycles
        tick();
        Dcache_Req = 1'b1; Dcache_We = 1'b1; Dcache_Addr = 32'h0000_2004;
        Dcache_Wdata = 32'h0000_55AA; Dcache_Wstrb = 4'b0011;
        @(negedge clk);
        gnt_count = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            Mem_Ready = (k == 4);
            @(negedge clk);
            check_val($sformatf("dw_c%0d_req", k), Mem_Req, 1'b1);
            check_val($sformatf("dw_c%0d_addr", k), Mem_Addr, 32'h0000_2004);
            check_val($sformatf("dw_c%0d_we", k), Mem_We, 1'b1);
            check_val($sformatf("dw_c%0d_wdata", k), Mem_Wdata, 32'h0000_55AA);
            check_val($sformatf("dw_c%0d_wstrb", k), Mem_Wstrb, 4'b0011);
            check_val($sformatf("dw_c%0d_igrant", k), Icache_Gnt, 1'b0);
            if (Dcache_Gnt) gnt_count++;
        end
        check_val("dw_gnt_pulses", gnt_count, 1);
        tick();
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h0;
        @(negedge clk);
        check_val("dw_ack", {Icache_Rvalid, Dcache_Rvalid}, 2'b01);
        check_val("dw_resp_mem_req", Mem_Req, 1'b0);
        tick();
        Dcache_Req = 1'b0; Dcache_We = 1'b0; Mem_Rvalid = 1'b0;
        @(negedge clk);
        check_val("dw_idle_busy", Arb_Busy, 1'b0);

        // Both requests held: expected grant order D,D,D,D,I,D,D,D,D,I
        exp_is_i = 10'b10_0001_0000;
        tick();
        Icache_Req = 1'b1; Icache_Addr = 32'h0000_6000;
        Dcache_Req = 1'b1; Dcache_Addr = 32'h0000_5000;
        Mem_Ready = 1'b1; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h1357_9BDF;
        ngrant = 0;
        for (int c = 0; c < 40 && ngrant < 10; c++) begin
            @(negedge clk);
            if (Icache_Gnt || Dcache_Gnt) begin
                check_val($sformatf("starve_grant%0d", ngrant), {Icache_Gnt, Dcache_Gnt},
                          exp_is_i[ngrant] ? 2'b10 : 2'b01);
                ngrant++;
            end
            if (ngrant < 10) tick();
        end
        check_val("starve_grant_count", ngrant, 10);
        tick();
        Icache_Req = 1'b0; Dcache_Req = 1'b0; Mem_Ready = 1'b0;
        @(negedge clk);
        check_val("starve_last_rvalid", {Icache_Rvalid, Dcache_Rvalid}, 2'b10);
        tick();
        Mem_Rvalid = 1'b0;
        @(negedge clk);
        check_val("starve_idle_busy", Arb_Busy, 1'b0);

        // Flush during Icache RESP, then a pending Dcache read
        tick();
        Icache_Req = 1'b1; Icache_Addr = 32'h0000_1100;
        @(negedge clk);
        tick();
        Mem_Ready = 1'b1; Dcache_Req = 1'b1; Dcache_We = 1'b0; Dcache_Addr = 32'h0000_3000;
        @(negedge clk);
        check_val("fl_gnts", {Icache_Gnt, Dcache_Gnt}, 2'b10);
        tick();
        Mem_Ready = 1'b0; Csr_Memflush = 1'b1;
        @(negedge clk);
        check_val("fl_resp_rvalid", Icache_Rvalid, 1'b0);
        tick();
        Csr_Memflush = 1'b0; Icache_Req = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h1234_5678;
        @(negedge clk);
        check_val("fl_dropped", {Icache_Rvalid, Dcache_Rvalid}, 2'b00);
        tick();
        Mem_Rvalid = 1'b0;
        @(negedge clk);
        check_val("fl_idle_busy", Arb_Busy, 1'b0);
        tick();
        Mem_Ready = 1'b1;
        @(negedge clk);
        check_val("fl_d_req", Mem_Req, 1'b1);
        check_val("fl_d_addr", Mem_Addr, 32'h0000_3000);
        check_val("fl_d_gnts", {Icache_Gnt, Dcache_Gnt}, 2'b01);
        tick();
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_val("fl_d_rvalids", {Icache_Rvalid, Dcache_Rvalid}, 2'b01);
        check_val("fl_d_rdata", Dcache_Rdata, 32'hCAFE_F00D);
        tick();
        Dcache_Req = 1'b0; Mem_Rvalid = 1'b0;

        // Flush in the same cycle as the Icache response
        Icache_Req = 1'b1; Icache_Addr = 32'h0000_7000;
        @(negedge clk);
        tick();
        Mem_Ready = 1'b1;
        @(negedge clk);
        check_val("fs_gnt", Icache_Gnt, 1'b1);
        tick();
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Csr_Memflush = 1'b1; Icache_Req = 1'b0;
        @(negedge clk);
        check_val("fs_rvalid", Icache_Rvalid, 1'b0);
        tick();
        Mem_Rvalid = 1'b0; Csr_Memflush = 1'b0;
        @(negedge clk);
        check_val("fs_idle_busy", Arb_Busy, 1'b0);

        // Reset asserted during REQ with Mem_Ready low
        tick();
        Dcache_Req = 1'b1; Dcache_We = 1'b1; Dcache_Addr = 32'h0000_8000;
        Dcache_Wdata = 32'hA5A5_A5A5; Dcache_Wstrb = 4'hF;
        @(negedge clk);
        tick();
        @(negedge clk);
        check_val("rst_pre_req", Mem_Req, 1'b1);
        #1;
        rst_n = 1'b0; Mem_Ready = 1'b1; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h1122_3344;
        #1;
        all_outputs_zero("rst_mid");
        check_val("rst_mid_drdata", Dcache_Rdata, 32'h1122_3344);
        check_val("rst_mid_irdata", Icache_Rdata, 32'h1122_3344);
        Dcache_Req = 1'b0; Dcache_We = 1'b0; Mem_Ready = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_stale_rvalid", {Icache_Rvalid, Dcache_Rvalid}, 2'b00);
        check_val("rst_stale_busy", Arb_Busy, 1'b0);
        tick();
        Mem_Rvalid = 1'b0; Dcache_Req = 1'b1; Dcache_Addr = 32'h0000_4008;
        @(negedge clk);
        check_val("rst_new_c0_req", Mem_Req, 1'b0);
        tick();
        Mem_Ready = 1'b1;
        @(negedge clk);
        check_val("rst_new_req", Mem_Req, 1'b1);
        check_val("rst_new_addr", Mem_Addr, 32'h0000_4008);
        check_val("rst_new_we", Mem_We, 1'b0);
        check_val("rst_new_gnt", Dcache_Gnt, 1'b1);
        tick();
        Mem_Ready = 1'b0; Mem_Rvalid = 1'b1; Mem_Rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check_val("rst_new_rvalid", Dcache_Rvalid, 1'b1);
        check_val("rst_new_rdata", Dcache_Rdata, 32'h0BAD_F00D);
        tick();
        Dcache_Req = 1'b0; Mem_Rvalid = 1'b0;
        @(negedge clk);

        // Mem_Rvalid while idle is ignored
        tick();
        Mem_Rvalid = 1'b1; Mem_Rdata = 32'hFFFF_0000;
        @(negedge clk);
        check_val("idle_rv_rvalids", {Icache_Rvalid, Dcache_Rvalid}, 2'b00);
        check_val("idle_rv_busy", Arb_Busy, 1'b0);
        tick();
        Mem_Rvalid = 1'b0;
        @(negedge clk);
        check_val("idle_rv_after_busy", Arb_Busy, 1'b0);
        check_val("idle_rv_after_req", Mem_Req, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single external memory port between the instruction-cache refill path and the data-cache access path. It sits between the two cache controllers and the memory bus, and allows one outstanding transaction at a time. Dcache has priority, with an anti-starvation limit for Icache. An Icache transaction in flight is dropped when the pipeline raises `Csr_Memflush`. Its busy output feeds the stall controller as an additional memory-stall source.

## Interface
- `STARVE_LIMIT`, default 4: maximum number of consecutive Dcache grants issued while Icache is waiting.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width. Strobe width is DATA_W/8.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Icache_Req`  in  1  Icache read request; level, held until `Icache_Rvalid` or until flushed.
- `Icache_Addr`  in  ADDR_W  Icache read address.
- `Icache_Gnt`  out  1  one-cycle pulse when the Icache request is accepted by memory.
- `Icache_Rvalid`  out  1  Icache response valid.
- `Icache_Rdata`  out  DATA_W  Icache response data.
- `Dcache_Req`  in  1  Dcache request; level, held until `Dcache_Rvalid`.
- `Dcache_We`  in  1  1 = write, 0 = read.
- `Dcache_Addr`  in  ADDR_W  Dcache address.
- `Dcache_Wdata`  in  DATA_W  Dcache write data.
- `Dcache_Wstrb`  in  DATA_W/8  Dcache byte enables.
- `Dcache_Gnt`  out  1  one-cycle pulse when the Dcache request is accepted by memory.
- `Dcache_Rvalid`  out  1  Dcache response valid (read data, or write acknowledge).
- `Dcache_Rdata`  out  DATA_W  Dcache response data.
- `Csr_Memflush`  in  1  pipeline flush; discards the response of an in-flight Icache transaction.
- `Mem_Req`  out  1  memory request valid.
- `Mem_We`  out  1  memory write enable.
- `Mem_Addr`  out  ADDR_W  memory address.
- `Mem_Wdata`  out  DATA_W  memory write data.
- `Mem_Wstrb`  out  DATA_W/8  memory byte enables.
- `Mem_Ready`  in  1  memory accepts the request in this cycle.
- `Mem_Rvalid`  in  1  memory response valid.
- `Mem_Rdata`  in  DATA_W  memory response data.
- `Arb_Busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states.
  - IDLE: arbitration happens here.
  - REQ: the request is presented on the memory port.
  - RESP: waiting for the memory response.
- Arbitration in IDLE:
  - If only one request is present, grant it.
  - If both are present, grant Dcache unless `starve_cnt == STARVE_LIMIT`; in that case grant Icache.
  - On a grant, latch the owner and the address/we/wdata/wstrb into registers, then go to REQ.
  - Requests seen in REQ or RESP are ignored; they are re-arbitrated on return to IDLE.
- `starve_cnt`, saturating at STARVE_LIMIT:
  - Increments on each Dcache grant made while `Icache_Req` is 1.
  - Clears on an Icache grant.
  - Clears when arbitration finds `Icache_Req` = 0.
- REQ:
  - `Mem_Req` = 1, driven from the latched registers only; it is never withdrawn, including on flush.
  - On `Mem_Ready` = 1, pulse the owner's Gnt in the same cycle and go to RESP.
- RESP:
  - On `Mem_Rvalid` = 1, route `Mem_Rdata`/`Mem_Rvalid` combinationally to the owner's Rdata/Rvalid and go to IDLE.
  - The non-owner's Rvalid stays 0.
  - Rdata outputs pass `Mem_Rdata` through; their value matters only while the matching Rvalid is 1.
- Flush, via `drop` flag:
  - `Csr_Memflush` = 1 while the owner is Icache in REQ or RESP sets `drop`.
  - While `drop` = 1, `Icache_Rvalid` is suppressed and `Icache_Gnt` still pulses.
  - `drop` clears on the return to IDLE.
  - Flush never affects Dcache ownership.
  - Flush in IDLE has no effect.
  - Flush in the same cycle as `Mem_Rvalid` suppresses that response.
- `Mem_Rvalid` outside RESP is ignored.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE; `starve_cnt`, `drop` and the owner register = 0.
  - All outputs = 0: Gnt, Rvalid, `Mem_Req`, `Mem_We`, `Mem_Addr`, `Mem_Wdata`, `Mem_Wstrb` and `Arb_Busy`, with Rdata following `Mem_Rdata`.
  - A response that arrives after reset is ignored.
- Minimum latency:
  - Request sampled in IDLE at cycle 0.
  - `Mem_Req` = 1 in cycle 1; with `Mem_Ready` = 1 in cycle 1, Gnt pulses in cycle 1.
  - Earliest `Mem_Rvalid`, and so requester Rvalid, is in cycle 2.
  - FSM is back in IDLE in cycle 3, and the next `Mem_Req` is in cycle 4.
  - Back-to-back transactions are therefore 3 cycles apart at best.
- `Arb_Busy` = 1 exactly in the REQ and RESP cycles.

## Test plan
- Single Icache read, addr 0x1000, memory ready immediately, Rdata 0xDEADBEEF: `Mem_Req` in cycle 1, `Icache_Gnt` in cycle 1, `Icache_Rvalid` with 0xDEADBEEF in cycle 2; `Dcache_Rvalid` stays 0.
- Dcache write, addr 0x2004, wdata 0x55AA, wstrb 4'b0011, `Mem_Ready` delayed 3 cycles: `Mem_*` held stable for 4 cycles and `Dcache_Gnt` pulses once.
- Both requests held continuously, STARVE_LIMIT = 4: grant order is D,D,D,D,I,D,D,D,D,I.
- Icache in RESP, `Csr_Memflush` pulsed, then `Mem_Rvalid`: `Icache_Rvalid` stays 0 and the next pending Dcache request is granted in the following IDLE.
- `rst_n` dropped during REQ with `Mem_Ready` = 0: all outputs 0 immediately; after release, a new Dcache request completes normally.
- `Mem_Rvalid` pulsed while in IDLE: no Rvalid output and no state change.
